// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: start/done control, instruction ROM port, branch redirect
// from execute and the valid/ready instruction-register handoff to decode.
interface fetch_unit_if #(
    parameter int unsigned PC_BITS = 12
);
    logic               start;
    logic               done;
    logic [PC_BITS-1:0] pc;
    logic [2:0]         im_instr;
    logic [2:0]         im_reg1;
    logic [2:0]         im_reg2;
    logic               branch_en;
    logic [PC_BITS-1:0] branch_target;
    logic               ir_valid;
    logic               ir_ready;
    logic [2:0]         ir_op;
    logic [2:0]         ir_reg1;
    logic [2:0]         ir_reg2;
    logic [PC_BITS-1:0] ir_pc;

    // Fetch unit side
    modport master (
        input  start, im_instr, im_reg1, im_reg2, branch_en, branch_target, ir_ready,
        output done, pc, ir_valid, ir_op, ir_reg1, ir_reg2, ir_pc
    );

    // Environment side (ROM, execute, decode, controller)
    modport slave (
        output start, im_instr, im_reg1, im_reg2, branch_en, branch_target, ir_ready,
        input  done, pc, ir_valid, ir_op, ir_reg1, ir_reg2, ir_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch stage in front of a combinational instruction ROM.
// Captures {op,reg1,reg2} into an instruction register with a valid/ready
// handoff, applies taken branches and stops on HALT_WORD.
// Optional feature macro FETCH_HALT_ON_WRAP_EN: halt after capturing the last
// PC instead of wrapping to 0.
module fetch_unit #(
    parameter int unsigned PC_BITS   = 12,
    parameter logic [8:0]  HALT_WORD = 9'h1FF
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             r_state;
    logic [PC_BITS-1:0] r_pc;
    logic [PC_BITS-1:0] r_ir_pc;
    logic [2:0]         r_ir_op;
    logic [2:0]         r_ir_reg1;
    logic [2:0]         r_ir_reg2;
    logic               r_ir_valid;
    logic               r_done;

    state_t             w_state_nxt;
    logic [PC_BITS-1:0] w_pc_nxt;
    logic [PC_BITS-1:0] w_ir_pc_nxt;
    logic [2:0]         w_ir_op_nxt;
    logic [2:0]         w_ir_reg1_nxt;
    logic [2:0]         w_ir_reg2_nxt;
    logic               w_ir_valid_nxt;
    logic               w_done_nxt;

    logic [8:0]         w_word;
    logic               w_slot;
    logic               w_is_halt;
`ifdef FETCH_HALT_ON_WRAP_EN
    logic               w_pc_max;
    assign w_pc_max  = &r_pc;
`endif

    assign w_word    = {bus.im_instr, bus.im_reg1, bus.im_reg2};
    assign w_slot    = !r_ir_valid || bus.ir_ready;
    assign w_is_halt = (w_word == HALT_WORD);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir_pc    <= '0;
            r_ir_op    <= '0;
            r_ir_reg1  <= '0;
            r_ir_reg2  <= '0;
            r_ir_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir_pc    <= w_ir_pc_nxt;
            r_ir_op    <= w_ir_op_nxt;
            r_ir_reg1  <= w_ir_reg1_nxt;
            r_ir_reg2  <= w_ir_reg2_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state: a branch always keeps RUN alive, even over a HALT word
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (!bus.branch_en && w_slot) begin
                    if (w_is_halt) begin
                        w_state_nxt = S_HALT;
                    end
`ifdef FETCH_HALT_ON_WRAP_EN
                    else if (w_pc_max) begin
                        w_state_nxt = S_HALT;
                    end
`endif
                end
            end
            S_HALT: if (bus.start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // PC, instruction register and done updates
    always_comb begin
        w_pc_nxt       = r_pc;
        w_ir_pc_nxt    = r_ir_pc;
        w_ir_op_nxt    = r_ir_op;
        w_ir_reg1_nxt  = r_ir_reg1;
        w_ir_reg2_nxt  = r_ir_reg2;
        w_ir_valid_nxt = r_ir_valid;
        w_done_nxt     = r_done;
        case (r_state)
            S_IDLE: begin
                w_ir_valid_nxt = 1'b0;
                w_done_nxt     = 1'b0;
                if (bus.start) w_pc_nxt = '0;
            end
            S_RUN: begin
                w_done_nxt = 1'b0;
                if (bus.branch_en) begin
                    w_pc_nxt       = bus.branch_target;
                    w_ir_valid_nxt = 1'b0;
                end else if (w_slot && w_is_halt) begin
                    // Open slot means the old IR is either empty or leaving now
                    w_ir_valid_nxt = 1'b0;
                end else if (w_slot) begin
                    w_ir_op_nxt    = bus.im_instr;
                    w_ir_reg1_nxt  = bus.im_reg1;
                    w_ir_reg2_nxt  = bus.im_reg2;
                    w_ir_pc_nxt    = r_pc;
                    w_ir_valid_nxt = 1'b1;
`ifdef FETCH_HALT_ON_WRAP_EN
                    if (!w_pc_max) w_pc_nxt = r_pc + PC_BITS'(1);
`else
                    w_pc_nxt = r_pc + PC_BITS'(1);
`endif
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    w_pc_nxt       = '0;
                    w_ir_valid_nxt = 1'b0;
                    w_done_nxt     = 1'b0;
                end else begin
                    if (bus.ir_ready) w_ir_valid_nxt = 1'b0;
                    w_done_nxt = !r_ir_valid;
                end
            end
            default: begin
                w_ir_valid_nxt = 1'b0;
                w_done_nxt     = 1'b0;
            end
        endcase
    end

    assign bus.pc       = r_pc;
    assign bus.ir_valid = r_ir_valid;
    assign bus.ir_op    = r_ir_op;
    assign bus.ir_reg1  = r_ir_reg1;
    assign bus.ir_reg2  = r_ir_reg2;
    assign bus.ir_pc    = r_ir_pc;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed programs push the expected
// {ir_pc, word} of every instruction decode should accept; a monitor pops and
// compares on each ir_valid && ir_ready handshake.
module tb_fetch_unit;

    localparam int unsigned PC_BITS = 12;

    typedef struct packed {
        logic [11:0] pc;
        logic [8:0]  word;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    logic [8:0] rom [0:4095];
    logic [8:0] rom_q;

    fetch_unit_if #(.PC_BITS(PC_BITS)) bus ();

    fetch_unit #(.PC_BITS(PC_BITS), .HALT_WORD(9'h1FF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign rom_q        = rom[bus.pc];
    assign bus.im_instr = rom_q[8:6];
    assign bus.im_reg1  = rom_q[5:3];
    assign bus.im_reg2  = rom_q[2:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] p, input logic [8:0] w);
        exp_t e;
        e.pc   = p;
        e.word = w;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(bus.done), 32'd1);
    endtask

    // Scoreboard monitor: every accepted IR must match the next expected entry
    always @(negedge clk) begin
        if (rst_n && bus.ir_valid && bus.ir_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got ir_pc 0x%0h word 0x%0h expected none at %0t",
                         bus.ir_pc, {bus.ir_op, bus.ir_reg1, bus.ir_reg2}, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_ir", {11'd0, bus.ir_pc, bus.ir_op, bus.ir_reg1, bus.ir_reg2},
                      {11'd0, e.pc, e.word});
            end
        end
    end

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        rst_n             = 1'b0;
        bus.start         = 1'b0;
        bus.branch_en     = 1'b0;
        bus.branch_target = '0;
        bus.ir_ready      = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = {1'b0, 8'(i)};

        #2;
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("idle_pc", 32'(bus.pc), 32'd0);

        // Basic program, decode always ready
        rom[0] = 9'h041; rom[1] = 9'h0C2; rom[2] = 9'h1FF;
        bus.ir_ready = 1'b1;
        push(12'h000, 9'h041);
        push(12'h001, 9'h0C2);
        pulse_start();
        check("a_pc0", 32'(bus.pc), 32'd0);
        check("a_valid0", 32'(bus.ir_valid), 32'd0);
        tick();
        check("a_first_valid", 32'(bus.ir_valid), 32'd1);
        check("a_pc1", 32'(bus.pc), 32'd1);
        tick();
        tick();
        check("a_halt_valid", 32'(bus.ir_valid), 32'd0);
        check("a_halt_pc", 32'(bus.pc), 32'd2);
        check("a_done_early", 32'(bus.done), 32'd0);
        tick();
        check("a_done", 32'(bus.done), 32'd1);

        // Stall for 3 cycles while IR holds the PC 2 word; start ignored in RUN
        rom[2] = 9'h0D3; rom[3] = 9'h0E4; rom[4] = 9'h1FF;
        push(12'h000, 9'h041);
        push(12'h001, 9'h0C2);
        push(12'h002, 9'h0D3);
        push(12'h003, 9'h0E4);
        pulse_start();
        check("b_done_clr", 32'(bus.done), 32'd0);
        tick();
        tick();
        tick();
        check("b_ir_pc2", 32'(bus.ir_pc), 32'd2);
        bus.ir_ready = 1'b0;
        bus.start    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.start = 1'b0;
            check("b_stall_pc", 32'(bus.pc), 32'd3);
            check("b_stall_ir_pc", 32'(bus.ir_pc), 32'd2);
            check("b_stall_word", 32'({bus.ir_op, bus.ir_reg1, bus.ir_reg2}), 32'h0D3);
            check("b_stall_valid", 32'(bus.ir_valid), 32'd1);
        end
        bus.ir_ready = 1'b1;
        wait_done("b_done");
        check("b_halt_pc", 32'(bus.pc), 32'd4);

        // Branch flushes a stalled IR
        rom[12'h010] = 9'h0A5; rom[12'h011] = 9'h1FF;
        bus.ir_ready = 1'b0;
        push(12'h010, 9'h0A5);
        pulse_start();
        tick();
        check("c_stall_valid", 32'(bus.ir_valid), 32'd1);
        bus.branch_en     = 1'b1;
        bus.branch_target = 12'h010;
        tick();
        bus.branch_en = 1'b0;
        check("c_br_pc", 32'(bus.pc), 32'h010);
        check("c_flush", 32'(bus.ir_valid), 32'd0);
        bus.ir_ready = 1'b1;
        tick();
        check("c_ir_pc", 32'(bus.ir_pc), 32'h010);
        wait_done("c_done");

        // Branch beats a HALT word at the current pc
        rom[0] = 9'h1FF; rom[12'h020] = 9'h0B6; rom[12'h021] = 9'h1FF;
        push(12'h020, 9'h0B6);
        pulse_start();
        bus.branch_en     = 1'b1;
        bus.branch_target = 12'h020;
        tick();
        bus.branch_en = 1'b0;
        check("d_br_pc", 32'(bus.pc), 32'h020);
        check("d_done", 32'(bus.done), 32'd0);
        tick();
        check("d_still_run", 32'(bus.ir_valid), 32'd1);
        check("d_ir_pc", 32'(bus.ir_pc), 32'h020);
        wait_done("d_done_end");

        // Run past the top of the PC range
        rom[12'hFFE] = 9'h011; rom[12'hFFF] = 9'h022; rom[0] = 9'h033; rom[1] = 9'h1FF;
        push(12'hFFE, 9'h011);
        push(12'hFFF, 9'h022);
`ifndef FETCH_HALT_ON_WRAP_EN
        push(12'h000, 9'h033);
`endif
        pulse_start();
        bus.branch_en     = 1'b1;
        bus.branch_target = 12'hFFE;
        tick();
        bus.branch_en = 1'b0;
        check("e_pc_top", 32'(bus.pc), 32'hFFE);
        tick();
        tick();
`ifdef FETCH_HALT_ON_WRAP_EN
        check("e_wrap_pc", 32'(bus.pc), 32'hFFF);
`else
        check("e_wrap_pc", 32'(bus.pc), 32'h000);
`endif
        wait_done("e_done");
`ifdef FETCH_HALT_ON_WRAP_EN
        check("e_final_pc", 32'(bus.pc), 32'hFFF);
`else
        check("e_final_pc", 32'(bus.pc), 32'h001);
`endif

        // Asynchronous reset in the middle of RUN at pc 5
        bus.ir_ready = 1'b0;
        pulse_start();
        bus.branch_en     = 1'b1;
        bus.branch_target = 12'h005;
        tick();
        bus.branch_en = 1'b0;
        check("f_pc5", 32'(bus.pc), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check("f_rst_pc", 32'(bus.pc), 32'd0);
        check("f_rst_valid", 32'(bus.ir_valid), 32'd0);
        check("f_rst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check("f_idle_pc", 32'(bus.pc), 32'd0);
        check("f_idle_valid", 32'(bus.ir_valid), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
